// File: rtl/duck_pkg.sv
// Shared constants for the duck sprite pipeline: screen and sprite
// geometry, motion tuning, FSM state codes and sprite_sel codes.
package duck_pkg;

  localparam int SCR_W          = 640;
  localparam int SCR_H          = 480;
  localparam int V_TICK         = 480;
  localparam int SPR_W          = 124;
  localparam int SPR_H          = 162;
  localparam int X_MAX          = SCR_W - SPR_W;
  localparam int Y_MAX          = SCR_H - SPR_H;
  localparam int Y_FLY_MAX      = 200;
  localparam int SPEED_X        = 3;
  localparam int SPEED_Y        = 2;
  localparam int FALL_SPEED     = 6;
  localparam int HIT_FRAMES     = 30;
  localparam int RESPAWN_FRAMES = 60;
  localparam int ANIM_DIV       = 8;

  localparam logic [1:0] ST_FLYING  = 2'd0;
  localparam logic [1:0] ST_HIT     = 2'd1;
  localparam logic [1:0] ST_FALLING = 2'd2;
  localparam logic [1:0] ST_RESPAWN = 2'd3;

  localparam logic [1:0] SEL_FLAP0 = 2'd0;
  localparam logic [1:0] SEL_FLAP1 = 2'd1;
  localparam logic [1:0] SEL_HIT   = 2'd2;
  localparam logic [1:0] SEL_FALL  = 2'd3;

endpackage

// File: rtl/duck_motion_ctrl_lfsr9.sv
// 9-bit maximal-length LFSR (x^9 + x^5 + 1), steps every cycle.
// Ports: vga_clk, reset (sync, active-high), value (never zero).
module lfsr9 (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [8:0] value
);

  logic [8:0] lfsr_q;
  logic [8:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
  end

  always_ff @(posedge vga_clk) begin
    if (reset) lfsr_q <= 9'h1FF;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/duck_motion_ctrl.sv
// Per-frame duck position / visibility / animation and hit-fall-respawn FSM.
// Ports: vga_clk, reset, hcount, vcount, hit in; duck_x, duck_y,
// duck_visible, sprite_sel, hit_count out (all registered).
module duck_motion_ctrl
  import duck_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hit,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic       duck_visible,
  output logic [1:0] sprite_sel,
  output logic [7:0] hit_count
);

  localparam logic [10:0] XMAX_W = 11'(X_MAX);
  localparam logic [10:0] YMAX_W = 11'(Y_MAX);
  localparam logic [10:0] YFLY_W = 11'(Y_FLY_MAX);
  localparam logic [10:0] SPX_W  = 11'(SPEED_X);
  localparam logic [10:0] SPY_W  = 11'(SPEED_Y);
  localparam logic [10:0] SPF_W  = 11'(FALL_SPEED);
  localparam logic [9:0]  XMAX   = 10'(X_MAX);
  localparam logic [9:0]  YMAX   = 10'(Y_MAX);
  localparam logic [9:0]  YFLY   = 10'(Y_FLY_MAX);
  localparam logic [9:0]  SPX    = 10'(SPEED_X);
  localparam logic [9:0]  SPY    = 10'(SPEED_Y);
  localparam logic [5:0]  HIT_LAST = 6'(HIT_FRAMES - 1);
  localparam logic [5:0]  RSP_LAST = 6'(RESPAWN_FRAMES - 1);
  localparam logic [2:0]  ANIM_LAST = 3'(ANIM_DIV - 1);

  logic [8:0]  lfsr;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic [1:0]  st_q, st_d;
  logic [1:0]  sel_q, sel_d;
  logic        vis_q, vis_d;
  logic [7:0]  hits_q, hits_d;
  logic [5:0]  frm_q, frm_d;
  logic [2:0]  anim_q, anim_d;
  logic        pend_q, pend_d;

  logic        tick;
  logic [10:0] x_up, y_up, y_fall;
  logic [9:0]  x_rsp;

  lfsr9 u_lfsr (
    .vga_clk (vga_clk),
    .reset   (reset),
    .value   (lfsr)
  );

  assign tick   = (hcount == 10'd0) && (vcount == 10'(V_TICK));
  assign x_up   = {1'b0, x_q} + SPX_W;
  assign y_up   = {1'b0, y_q} + SPY_W;
  assign y_fall = {1'b0, y_q} + SPF_W;
  // Fold LFSR values past the right edge back onto the screen.
  assign x_rsp  = ({1'b0, lfsr} > XMAX) ? ({1'b0, lfsr} - 10'd256)
                                        : {1'b0, lfsr};

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    st_d    = st_q;
    sel_d   = sel_q;
    vis_d   = vis_q;
    hits_d  = hits_q;
    frm_d   = frm_q;
    anim_d  = anim_q;
    pend_d  = pend_q;

    if (st_q == ST_FLYING && hit) pend_d = 1'b1;

    if (tick) begin
      unique case (st_q)
        ST_FLYING: begin
          // A hit landing on the tick cycle itself still counts now.
          if (pend_q || hit) begin
            st_d   = ST_HIT;
            sel_d  = SEL_HIT;
            frm_d  = '0;
            pend_d = 1'b0;
            if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
          end else begin
            if (dir_x_q) begin
              if (x_up >= XMAX_W) begin
                x_d     = XMAX;
                dir_x_d = 1'b0;
              end else begin
                x_d = x_up[9:0];
              end
            end else if ({1'b0, x_q} < SPX_W) begin
              x_d     = '0;
              dir_x_d = 1'b1;
            end else begin
              x_d = x_q - SPX;
            end

            if (dir_y_q) begin
              if (y_up >= YFLY_W) begin
                y_d     = YFLY;
                dir_y_d = 1'b0;
              end else begin
                y_d = y_up[9:0];
              end
            end else if ({1'b0, y_q} < SPY_W) begin
              y_d     = '0;
              dir_y_d = 1'b1;
            end else begin
              y_d = y_q - SPY;
            end

            if (anim_q == ANIM_LAST) begin
              anim_d = '0;
              sel_d  = {1'b0, ~sel_q[0]};
            end else begin
              anim_d = anim_q + 3'd1;
            end
          end
        end
        ST_HIT: begin
          if (frm_q == HIT_LAST) begin
            st_d  = ST_FALLING;
            sel_d = SEL_FALL;
            frm_d = '0;
          end else begin
            frm_d = frm_q + 6'd1;
          end
        end
        ST_FALLING: begin
          if (y_fall >= YMAX_W) begin
            y_d   = YMAX;
            vis_d = 1'b0;
            st_d  = ST_RESPAWN;
            frm_d = '0;
          end else begin
            y_d = y_fall[9:0];
          end
        end
        ST_RESPAWN: begin
          if (frm_q == RSP_LAST) begin
            x_d     = x_rsp;
            y_d     = YFLY;
            dir_y_d = 1'b0;
            dir_x_d = lfsr[0];
            vis_d   = 1'b1;
            sel_d   = SEL_FLAP0;
            st_d    = ST_FLYING;
            frm_d   = '0;
            anim_d  = '0;
          end else begin
            frm_d = frm_q + 6'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= 10'd100;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      st_q    <= ST_FLYING;
      sel_q   <= SEL_FLAP0;
      vis_q   <= 1'b1;
      hits_q  <= '0;
      frm_q   <= '0;
      anim_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      st_q    <= st_d;
      sel_q   <= sel_d;
      vis_q   <= vis_d;
      hits_q  <= hits_d;
      frm_q   <= frm_d;
      anim_q  <= anim_d;
      pend_q  <= pend_d;
    end
  end

  assign duck_x       = x_q;
  assign duck_y       = y_q;
  assign duck_visible = vis_q;
  assign sprite_sel   = sel_q;
  assign hit_count    = hits_q;

endmodule

// File: tb/tb_duck_motion_ctrl.sv
// Self-checking bench for duck_motion_ctrl: random stimulus against a
// behavioural frame-level model, checked every cycle.
module tb_duck_motion_ctrl;

  localparam int FLY  = 0;
  localparam int HITP = 1;
  localparam int FALL = 2;
  localparam int RESP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount;
  logic       hit;
  logic [9:0] duck_x, duck_y;
  logic       duck_visible;
  logic [1:0] sprite_sel;
  logic [7:0] hit_count;

  int n_chk = 0;
  int n_err = 0;

  int m_st, m_x, m_y, m_dx, m_dy, m_vis, m_sel;
  int m_hits, m_frames, m_flaps, m_pend, m_lfsr;

  always #5 clk = ~clk;

  duck_motion_ctrl dut (
    .vga_clk      (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .hit          (hit),
    .duck_x       (duck_x),
    .duck_y       (duck_y),
    .duck_visible (duck_visible),
    .sprite_sel   (sprite_sel),
    .hit_count    (hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit rst, input bit h, input bit t);
    int old;
    if (rst) begin
      m_st = FLY; m_x = 0; m_y = 100; m_dx = 1; m_dy = 1;
      m_vis = 1; m_sel = 0; m_hits = 0; m_frames = 0;
      m_flaps = 0; m_pend = 0; m_lfsr = 511;
      return;
    end
    old = m_lfsr;
    m_lfsr = ((m_lfsr * 2) % 512) + (((m_lfsr / 256) + (m_lfsr / 16)) % 2);
    if (m_st == FLY && h && !t) m_pend = 1;
    if (!t) return;
    case (m_st)
      FLY: begin
        if (m_pend == 1 || h) begin
          m_st = HITP; m_sel = 2; m_frames = 0; m_pend = 0;
          m_hits = (m_hits < 255) ? m_hits + 1 : 255;
        end else begin
          if (m_dx > 0) begin
            if (m_x + 3 >= 516) begin m_x = 516; m_dx = -1; end
            else m_x = m_x + 3;
          end else if (m_x < 3) begin m_x = 0; m_dx = 1; end
          else m_x = m_x - 3;
          if (m_dy > 0) begin
            if (m_y + 2 >= 200) begin m_y = 200; m_dy = -1; end
            else m_y = m_y + 2;
          end else if (m_y < 2) begin m_y = 0; m_dy = 1; end
          else m_y = m_y - 2;
          m_flaps++;
          m_sel = (m_flaps / 8) % 2;
        end
      end
      HITP: begin
        m_frames++;
        if (m_frames == 30) begin m_st = FALL; m_sel = 3; m_frames = 0; end
      end
      FALL: begin
        if (m_y + 6 >= 318) begin
          m_y = 318; m_vis = 0; m_st = RESP; m_frames = 0;
        end else m_y = m_y + 6;
      end
      default: begin
        m_frames++;
        if (m_frames == 60) begin
          m_x = (old > 516) ? old - 256 : old;
          m_y = 200; m_dy = -1; m_dx = (old % 2 == 1) ? 1 : -1;
          m_vis = 1; m_sel = 0; m_st = FLY; m_flaps = 0; m_frames = 0;
        end
      end
    endcase
  endfunction

  task automatic cyc(input bit rst, input bit h,
                     input logic [9:0] hc, input logic [9:0] vc);
    reset = rst; hit = h; hcount = hc; vcount = vc;
    @(posedge clk);
    model(rst, h, hc == 0 && vc == 480);
    #1;
    chk("duck_x", duck_x, m_x);
    chk("duck_y", duck_y, m_y);
    chk("visible", duck_visible, m_vis);
    chk("sprite_sel", sprite_sel, m_sel);
    chk("hit_count", hit_count, m_hits);
    chk("in_range", duck_x <= 516 && duck_y <= 318, 1);
  endtask

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic idle(input bit h);
    logic [9:0] hc, vc;
    case ($urandom_range(0, 2))
      0: begin hc = 10'd0; vc = 10'($urandom_range(0, 479)); end
      1: begin hc = 10'($urandom_range(1, 799)); vc = 10'd480; end
      default: begin
        hc = 10'($urandom_range(1, 799));
        vc = 10'($urandom_range(481, 524));
      end
    endcase
    cyc(1'b0, h, hc, vc);
  endtask

  task automatic frame(input int gap, input int pct);
    cyc(1'b0, rnd(pct), 10'd0, 10'd480);
    repeat (gap) idle(rnd(pct));
  endtask

  task automatic until_fly(input string tag, input int pct);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_st == FLY) begin ok = 1; break; end
      frame(1, (m_st == FLY) ? 0 : pct);
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    reset = 1'b1; hit = 1'b0; hcount = '0; vcount = '0;
    m_lfsr = 511;
    cyc(1'b1, 1'b0, 10'd5, 10'd5);
    cyc(1'b1, 1'b0, 10'd0, 10'd480);
    chk("rst_x", duck_x, 0);
    chk("rst_y", duck_y, 100);

    // first frame: move exactly once, then hold
    frame(6, 0);
    chk("t1_x", duck_x, 3);
    chk("t1_y", duck_y, 102);

    // sweep right to the clamp and back to the left edge
    for (int i = 0; i < 360; i++) frame(1, 0);

    // hit mid-frame, then hold in HIT, fall, respawn
    cyc(1'b0, 1'b1, 10'd100, 10'd50);
    frame(1, 0);
    chk("hit_sel", sprite_sel, 2);
    chk("hit_cnt1", hit_count, 1);
    for (int i = 0; i < 30; i++) frame(1, 0);
    chk("fall_sel", sprite_sel, 3);
    until_fly("respawn1", 30);
    chk("rsp_vis", duck_visible, 1);
    chk("rsp_y", duck_y, 200);
    chk("rsp_sel", sprite_sel, 0);
    chk("rsp_cnt", hit_count, 1);

    // hit on the tick cycle itself
    cyc(1'b0, 1'b1, 10'd0, 10'd480);
    chk("tick_hit_sel", sprite_sel, 2);
    chk("tick_hit_cnt", hit_count, 2);
    until_fly("respawn2", 0);

    // three hits in one frame count once
    idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b1);
    frame(1, 0);
    chk("multi_hit", hit_count, 3);
    until_fly("respawn3", 0);

    // random phase
    for (int i = 0; i < 300; i++) frame($urandom_range(1, 3), 3);
    until_fly("respawn4", 20);

    // reset while falling
    idle(1'b1);
    for (int i = 0; i < 40 && m_st != FALL; i++) frame(1, 0);
    frame(1, 0); frame(1, 0);
    chk("mid_fall_sel", sprite_sel, 3);
    cyc(1'b1, 1'b0, 10'd7, 10'd7);
    chk("mf_rst_x", duck_x, 0);
    chk("mf_rst_y", duck_y, 100);
    chk("mf_rst_vis", duck_visible, 1);
    chk("mf_rst_cnt", hit_count, 0);

    // saturation: tick and hit every cycle
    for (int i = 0; i < 45000 && m_hits < 255; i++)
      cyc(1'b0, 1'b1, 10'd0, 10'd480);
    chk("sat_reach", hit_count, 255);
    repeat (300) cyc(1'b0, 1'b1, 10'd0, 10'd480);
    chk("sat_hold", hit_count, 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/duck_motion_ctrl.md
Name: duck_motion_ctrl

Overview:
Upstream stage of Ducks_Drawer. Computes the duck sprite's on-screen position, its visibility and its animation frame, once per video frame. It watches the VGA counters to find the frame boundary. It also runs the hit/fall/respawn state machine. Its outputs feed Ducks_Drawer, which uses them to offset sprite ROM addressing against hcount/vcount.

Parameters:
SPR_W, 124, sprite width in pixels
SPR_H, 162, sprite height in pixels
X_MAX, 516, rightmost legal duck_x (640-SPR_W)
Y_MAX, 318, lowest legal duck_y (480-SPR_H); fall terminates here
Y_FLY_MAX, 200, lowest duck_y while flying
SPEED_X, 3, pixels per frame horizontally
SPEED_Y, 2, pixels per frame vertically in flight
FALL_SPEED, 6, pixels per frame while falling
HIT_FRAMES, 30, frames held in HIT pose
RESPAWN_FRAMES, 60, invisible frames before respawn
ANIM_DIV, 8, frames per wing-flap toggle
V_TICK, 480, vcount value that marks the frame tick

Ports:
vga_clk  in  1  pixel clock, single clock domain
reset  in  1  synchronous, active-high
hcount  in  10  current pixel column from VGA_LOGIC
vcount  in  10  current line from VGA_LOGIC
hit  in  1  single-cycle pulse: the shot landed on the duck
duck_x  out  10  sprite left edge
duck_y  out  10  sprite top edge
duck_visible  out  1  Ducks_Drawer draws only when 1
sprite_sel  out  2  0/1 = flap frames, 2 = hit pose, 3 = falling
hit_count  out  8  number of ducks hit, saturating at 255

Behaviour:
- Frame tick: the sampled condition hcount==0 && vcount==V_TICK. It occurs once per frame, at the start of vblank. All position and state updates happen on the clock edge where it is sampled. Outputs are registered, so they change 1 cycle after the tick sample and stay stable for the whole active region.
- Reset, synchronous:
  - duck_x=0, duck_y=100, dir_x=right, dir_y=down.
  - State FLYING, duck_visible=1, sprite_sel=0, hit_count=0.
  - Frame counters 0, hit_pending=0, LFSR=9'h1FF.
  - Reset asserted mid-fall or mid-respawn returns to exactly these values on the next edge.
- LFSR: 9-bit maximal-length, taps 9 and 5. It advances every vga_clk cycle and never reaches 0.
- States:
  - FLYING:
    - x moves by SPEED_X in dir_x. If the right move would give x>=X_MAX, clamp x=X_MAX and set dir_x=left. If a left move is attempted with x<SPEED_X, clamp x=0 and set dir_x=right.
    - y moves the same way by SPEED_Y, bounded to 0..Y_FLY_MAX.
    - sprite_sel[0] toggles every ANIM_DIV ticks; sprite_sel[1]=0.
    - If hit_pending is set at a tick: go to HIT, hit_count++ (saturating), clear hit_pending, clear the frame counter, and do not move on that tick.
  - HIT: position frozen, sprite_sel=2. After HIT_FRAMES ticks, go to FALLING.
  - FALLING: per tick, y+=FALL_SPEED with x frozen; sprite_sel=3. If y+FALL_SPEED>=Y_MAX, clamp y=Y_MAX, set duck_visible=0 and go to RESPAWN.
  - RESPAWN: invisible for RESPAWN_FRAMES ticks. On the exit tick:
    - x = LFSR value, minus 256 if it is >X_MAX.
    - y=Y_FLY_MAX, dir_y=up, dir_x=LFSR bit0.
    - duck_visible=1, sprite_sel=0, state FLYING.
- hit handling:
  - A hit in any cycle while in FLYING sets hit_pending.
  - A hit coincident with the tick counts for that tick.
  - A hit in HIT, FALLING or RESPAWN is ignored and does not increment hit_count.
  - Multiple hits before one tick count as one.
- Width rule: all position arithmetic is done in 11 bits to detect overflow and underflow before clamping. Outputs never leave 0..X_MAX and 0..Y_MAX.

Decomposition:
- duck_pkg holds:
  - the state enum (FLYING=0, HIT=1, FALLING=2, RESPAWN=3);
  - sprite_sel codes;
  - screen constants: 640, 480, V_TICK;
  - SPR_W and SPR_H, shared with Ducks_Drawer.
- One sub-module: lfsr9 (vga_clk, reset, 9-bit value out).

Test Plan:
1. Reset, then run 1 frame. Required: duck_x 0→3 and duck_y 100→102, changing exactly 1 cycle after the tick sample; no other change during that frame.
2. Start FLYING at x=515 with dir right, then tick. Required: x=516, dir left. Next tick: x=513. Start at x=2 moving left, then tick. Required: x=0, dir right.
3. Pulse hit at vcount=50. Required at the next tick: HIT, sprite_sel=2, hit_count=1. After 30 ticks: FALLING, sprite_sel=3, y grows by 6 per tick until clamped at 318; then duck_visible=0.
4. Pulse hit during FALLING, then during RESPAWN. Required: hit_count unchanged. After 60 invisible ticks: visible=1, y=200, x≤516, sprite_sel=0.
5. Pulse hit on the same cycle as the tick sample. Required: HIT taken on that tick. Pulse hit 3 times within one frame. Required: hit_count increments by exactly 1.
6. Assert reset mid-FALLING. Required on the next edge: x=0, y=100, visible=1, hit_count=0, state FLYING. With hit_count at 255, a further hit leaves it at 255.
